// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table capture block.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAP  = 2'd1,
        DONE = 2'd2
    } tt_state_t;

    localparam int unsigned TT_MAX = 64;

    function automatic int unsigned tt_depth(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/tt_cov_tracker.sv
// Coverage tracker: seen mask, first-write-wins table, all-seen and differing-duplicate detect.
module tt_cov_tracker
    import tt_pkg::*;
#(
    parameter int unsigned N_IN = 3,
    parameter int unsigned TT   = tt_depth(N_IN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            wr_en,
    input  logic [N_IN-1:0] wr_idx,
    input  logic            wr_y,
    output logic [TT-1:0]   seen,
    output logic [TT-1:0]   tt,
    output logic [TT-1:0]   tt_nxt,
    output logic            all_seen_nxt,
    output logic            diff_hit
);

    logic [TT-1:0] seen_nxt;

    // Next-state values are exported so the top can register checks in step with done.
    always_comb begin
        tt_nxt   = tt;
        seen_nxt = seen;
        if (clear) begin
            tt_nxt   = '0;
            seen_nxt = '0;
        end else if (wr_en && !seen[wr_idx]) begin
            tt_nxt[wr_idx]   = wr_y;
            seen_nxt[wr_idx] = 1'b1;
        end
    end

    assign all_seen_nxt = &seen_nxt;
    assign diff_hit     = wr_en & seen[wr_idx] & (tt[wr_idx] != wr_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            tt   <= '0;
            seen <= '0;
        end else begin
            tt   <= tt_nxt;
            seen <= seen_nxt;
        end
    end

endmodule

// File: rtl/tt_capture.sv
// Truth-table capture top: FSM, sample counter, conflict flag.
// Optional expected-table compare enabled by `TT_EXPECT_CHECK_EN.
module tt_capture
    import tt_pkg::*;
#(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TT    = tt_depth(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             smp_valid,
    input  logic [N_IN-1:0]  smp_in,
    input  logic             smp_y,
`ifdef TT_EXPECT_CHECK_EN
    input  logic [TT-1:0]    expect_tt,
    output logic [TT-1:0]    mismatch,
    output logic             pass,
`endif
    output logic             smp_ready,
    output logic [TT-1:0]    tt_out,
    output logic [TT-1:0]    seen,
    output logic             conflict,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] smp_cnt
);

    tt_state_t     state, state_nxt;
    logic          accept;
    logic          all_seen_nxt;
    logic          diff_hit;
    logic [TT-1:0] tt_nxt;

    assign smp_ready = (state == CAP);
    assign busy      = (state == CAP);
    assign done      = (state == DONE);
    // start wins over a same-cycle sample.
    assign accept    = smp_valid & smp_ready & ~start;

    tt_cov_tracker #(
        .N_IN (N_IN),
        .TT   (TT)
    ) u_cov (
        .clk          (clk),
        .reset        (reset),
        .clear        (start),
        .wr_en        (accept),
        .wr_idx       (smp_in),
        .wr_y         (smp_y),
        .seen         (seen),
        .tt           (tt_out),
        .tt_nxt       (tt_nxt),
        .all_seen_nxt (all_seen_nxt),
        .diff_hit     (diff_hit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CAP;
            CAP:     if (start) state_nxt = CAP;
                     else if (accept && all_seen_nxt) state_nxt = DONE;
            DONE:    if (start) state_nxt = CAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            smp_cnt  <= '0;
            conflict <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                smp_cnt  <= '0;
                conflict <= 1'b0;
            end else if (accept) begin
                if (smp_cnt != '1) smp_cnt <= smp_cnt + 1'b1;
                if (diff_hit) conflict <= 1'b1;
            end
        end
    end

`ifdef TT_EXPECT_CHECK_EN
    // The final write can never be a conflict (its index was unseen), so conflict is current.
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch <= '0;
            pass     <= 1'b0;
        end else if (state_nxt == DONE) begin
            mismatch <= tt_nxt ^ expect_tt;
            pass     <= ((tt_nxt ^ expect_tt) == '0) & ~conflict;
        end else begin
            mismatch <= '0;
            pass     <= 1'b0;
        end
    end
`endif

endmodule
